// File: rtl/em_pkg.sv
// Shared encodings for the external-memory access master: access sizes,
// memory control codes and default geometry.
package em_pkg;
    localparam int ADDR_W        = 10;
    localparam int MEM_SIZE_DEF  = 96;
    localparam int MAX_BEATS_DEF = 16;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    typedef enum logic [2:0] {
        EM_NONE = 3'd0,
        EM_WB   = 3'd1,
        EM_WH   = 3'd2,
        EM_WW   = 3'd3
    } ctl_e;

    // Size code 3 has no meaning of its own and behaves as a word access.
    function automatic size_e norm_size(input logic [1:0] s);
        return (s == 2'd3) ? SZ_WORD : size_e'(s);
    endfunction
endpackage

// File: rtl/em_access_master_if.sv
// Request / store-data / response handshakes plus the external memory bus,
// bundled for the access master (master modport) and its environment (slave).
interface em_access_master_if #(
    parameter int BEATS_W = 4
);
    import em_pkg::*;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [1:0]            req_size;
    logic                  req_signed;
    logic [ADDR_W-1:0]     req_addr;
    logic [BEATS_W-1:0]    req_beats;
    logic                  wd_valid;
    logic                  wd_ready;
    logic [31:0]           wd_data;
    logic                  rsp_valid;
    logic [31:0]           rsp_data;
    logic                  rsp_fault;
    logic                  rsp_last;
    logic [2:0]            em_control;
    logic [4*ADDR_W-1:0]   em_address;
    logic [7:0]            em_dw0;
    logic [7:0]            em_dw1;
    logic [7:0]            em_dw2;
    logic [7:0]            em_dw3;
    logic [31:0]           em_read;

    modport master (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_beats,
        input  wd_valid, wd_data, em_read,
        output req_ready, wd_ready, rsp_valid, rsp_data, rsp_fault, rsp_last,
        output em_control, em_address, em_dw0, em_dw1, em_dw2, em_dw3
    );

    modport slave (
        output req_valid, req_write, req_size, req_signed, req_addr, req_beats,
        output wd_valid, wd_data, em_read,
        input  req_ready, wd_ready, rsp_valid, rsp_data, rsp_fault, rsp_last,
        input  em_control, em_address, em_dw0, em_dw1, em_dw2, em_dw3
    );
endinterface

// File: rtl/em_load_extend.sv
// Extracts the byte or halfword of a load from the memory read word and
// zero/sign extends it to 32 bits; words pass through.
module em_load_extend
    import em_pkg::*;
(
    input  logic [31:0] rd_word,
    input  size_e       size,
    input  logic        is_signed,
    output logic [31:0] ext_word
);
    always_comb begin
        ext_word = rd_word;
        case (size)
            SZ_BYTE: ext_word = {{24{is_signed & rd_word[7]}}, rd_word[7:0]};
            SZ_HALF: ext_word = {{16{is_signed & rd_word[15]}}, rd_word[15:0]};
            default: ;
        endcase
    end
endmodule

// File: rtl/em_access_master.sv
// Load/store initiator for the byte-addressed external memory: one memory
// cycle per beat, one response per beat. Define EM_ACCESS_MISALIGN_FAULT_EN to fault misaligned half/word accesses.
module em_access_master
    import em_pkg::*;
#(
    parameter int MEM_SIZE  = MEM_SIZE_DEF,
    parameter int MAX_BEATS = MAX_BEATS_DEF
) (
    input  logic                clock,
    input  logic                reset,
    em_access_master_if.master  bus
);
    localparam int BEATS_W = $clog2(MAX_BEATS);

    typedef enum logic {IDLE, BEAT} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                write_q, write_d;
    size_e               size_q, size_d;
    logic                signed_q, signed_d;
    logic [BEATS_W-1:0]  beats_q, beats_d;
    logic [BEATS_W-1:0]  count_q, count_d;
    logic [4*ADDR_W-1:0] addr_hold_q, addr_hold_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_fault_q, rsp_fault_d;
    logic                rsp_last_q, rsp_last_d;
    logic [31:0]         rsp_data_q, rsp_data_d;

    logic [ADDR_W-1:0]   cur, a0, a1, a2, a3;
    logic [4*ADDR_W-1:0] lanes;
    logic                fault, fire, done, in_beat;
    logic [31:0]         ext_data;

    assign in_beat = (state_q == BEAT);
    assign cur     = addr_q + (ADDR_W'(count_q) << 2);

    // Narrow accesses replicate their lanes so an in-range read never sees
    // the memory's all-zero out-of-range answer.
    always_comb begin
        a0 = cur;
        a1 = cur;
        a2 = cur;
        a3 = cur;
        case (size_q)
            SZ_WORD: begin
                a1 = cur + ADDR_W'(1);
                a2 = cur + ADDR_W'(2);
                a3 = cur + ADDR_W'(3);
            end
            SZ_HALF: begin
                a1 = cur + ADDR_W'(1);
                a2 = cur + ADDR_W'(1);
                a3 = cur + ADDR_W'(1);
            end
            default: ;
        endcase
    end
    assign lanes = {a3, a2, a1, a0};

    always_comb begin
        fault = (int'(a0) >= MEM_SIZE);
        case (size_q)
            SZ_HALF: fault = fault | (int'(a1) >= MEM_SIZE);
            SZ_WORD: fault = fault | (int'(a1) >= MEM_SIZE) | (int'(a2) >= MEM_SIZE)
                                   | (int'(a3) >= MEM_SIZE);
            default: ;
        endcase
`ifdef EM_ACCESS_MISALIGN_FAULT_EN
        if ((size_q == SZ_HALF && cur[0]) || (size_q == SZ_WORD && cur[1:0] != 2'b00))
            fault = 1'b1;
`endif
    end

    assign fire = in_beat && (!write_q || bus.wd_valid);
    assign done = fault || (count_q == beats_q);

    em_load_extend u_ext (
        .rd_word  (bus.em_read),
        .size     (size_q),
        .is_signed(signed_q),
        .ext_word (ext_data)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        write_d     = write_q;
        size_d      = size_q;
        signed_d    = signed_q;
        beats_d     = beats_q;
        count_d     = count_q;
        addr_hold_d = addr_hold_q;
        rsp_valid_d = 1'b0;
        rsp_fault_d = 1'b0;
        rsp_last_d  = 1'b0;
        rsp_data_d  = rsp_data_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_d   = bus.req_addr;
                    write_d  = bus.req_write;
                    size_d   = norm_size(bus.req_size);
                    signed_d = bus.req_signed;
                    beats_d  = (norm_size(bus.req_size) == SZ_WORD) ? bus.req_beats : '0;
                    count_d  = '0;
                    state_d  = BEAT;
                end
            end
            BEAT: begin
                addr_hold_d = lanes;
                if (fire) begin
                    rsp_valid_d = 1'b1;
                    rsp_fault_d = fault;
                    rsp_last_d  = done;
                    rsp_data_d  = (write_q || fault) ? 32'd0 : ext_data;
                    if (done) state_d = IDLE;
                    else      count_d = count_q + 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        bus.em_control = EM_NONE;
        bus.em_dw0     = 8'd0;
        bus.em_dw1     = 8'd0;
        bus.em_dw2     = 8'd0;
        bus.em_dw3     = 8'd0;
        if (in_beat && write_q && bus.wd_valid && !fault && reset) begin
            case (size_q)
                SZ_BYTE: bus.em_control = EM_WB;
                SZ_HALF: bus.em_control = EM_WH;
                default: bus.em_control = EM_WW;
            endcase
            {bus.em_dw3, bus.em_dw2, bus.em_dw1, bus.em_dw0} = bus.wd_data;
        end
    end

    assign bus.em_address = in_beat ? lanes : addr_hold_q;
    assign bus.req_ready  = (state_q == IDLE) && reset;
    assign bus.wd_ready   = in_beat && write_q && reset;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_fault  = rsp_fault_q;
    assign bus.rsp_last   = rsp_last_q;
    assign bus.rsp_data   = rsp_data_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            write_q     <= 1'b0;
            size_q      <= SZ_BYTE;
            signed_q    <= 1'b0;
            beats_q     <= '0;
            count_q     <= '0;
            addr_hold_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_fault_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            size_q      <= size_d;
            signed_q    <= signed_d;
            beats_q     <= beats_d;
            count_q     <= count_d;
            addr_hold_q <= addr_hold_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_fault_q <= rsp_fault_d;
            rsp_last_q  <= rsp_last_d;
            rsp_data_q  <= rsp_data_d;
        end
    end
endmodule

// File: tb/tb_em_access_master.sv
// Randomized bench for em_access_master: byte-array memory environment plus a
// request-level reference model that predicts responses, writes and memory image.
module tb_em_access_master;
    import em_pkg::*;

    localparam int MEM = 96;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    em_access_master_if bus ();

    em_access_master #(.MEM_SIZE(MEM), .MAX_BEATS(16)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    logic [7:0] mem     [0:MEM-1];
    logic [7:0] ref_mem [0:MEM-1];
    logic [9:0] la      [4];
    bit         load_mem = 1'b0;
    int         wr_cnt = 0;
    int         cyc = 0;
    int         n_chk = 0;
    int         n_fail = 0;
    int         last_acc = -100;
    logic [31:0] wd_in [$];

    always_comb begin
        for (int k = 0; k < 4; k++) la[k] = bus.em_address[10*k +: 10];
    end

    always_comb begin
        bus.em_read = 32'd0;
        if (int'(la[0]) < MEM && int'(la[1]) < MEM && int'(la[2]) < MEM && int'(la[3]) < MEM)
            bus.em_read = {mem[la[3]], mem[la[2]], mem[la[1]], mem[la[0]]};
    end

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (load_mem) begin
            for (int i = 0; i < MEM; i++) mem[i] <= ref_mem[i];
        end else if (bus.em_control != 3'd0) begin
            wr_cnt <= wr_cnt + 1;
            if (int'(la[0]) < MEM) mem[la[0]] <= bus.em_dw0;
            if (bus.em_control >= 3'd2 && int'(la[1]) < MEM) mem[la[1]] <= bus.em_dw1;
            if (bus.em_control == 3'd3 && int'(la[2]) < MEM) mem[la[2]] <= bus.em_dw2;
            if (bus.em_control == 3'd3 && int'(la[3]) < MEM) mem[la[3]] <= bus.em_dw3;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [39:0] exp_lanes(input logic [9:0] c, input int nb);
        if (nb == 1) return {c, c, c, c};
        if (nb == 2) return {c + 10'd1, c + 10'd1, c + 10'd1, c};
        return {c + 10'd3, c + 10'd2, c + 10'd1, c};
    endfunction

    // One request end to end: predict it, drive it, check every cycle.
    task automatic do_req(input bit wr, input logic [1:0] sz, input bit sg, input logic [9:0] addr,
                          input logic [3:0] beats, input int stall_pct, input int gap_fix,
                          input bit chk_gap);
        int nb, eff, code, idx, acc, wr0, budget;
        int n_exp = 0, n_wr = 0, got = 0, used = 0, gap = 0;
        logic [31:0] e_data [16];
        logic [31:0] e_wd   [16];
        bit          e_flt  [16];
        bit          e_last [16];
        bit          fin = 1'b0;
        logic [9:0]  c;
        logic [31:0] v;
        nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        code = (nb == 1) ? 1 : (nb == 2) ? 2 : 3;
        eff  = (nb == 4) ? int'(beats) : 0;
        for (int b = 0; b <= eff; b++) begin
            bit f;
            f = 1'b0;
            c = addr + 10'(4 * b);
            for (int k = 0; k < nb; k++) if (int'(c + 10'(k)) >= MEM) f = 1'b1;
`ifdef EM_ACCESS_MISALIGN_FAULT_EN
            if ((nb == 2 && c[0]) || (nb == 4 && c[1:0] != 2'b00)) f = 1'b1;
`endif
            e_wd[b] = (b < wd_in.size()) ? wd_in[b] : $urandom;
            v = 32'd0;
            if (!f) begin
                for (int k = 0; k < nb; k++) begin
                    if (wr) ref_mem[c + 10'(k)] = e_wd[b][8*k +: 8];
                    else    v |= 32'(ref_mem[c + 10'(k)]) << (8 * k);
                end
                if (wr) n_wr++;
            end
            if (!wr && sg && nb == 1 && v[7])  v |= 32'hFFFF_FF00;
            if (!wr && sg && nb == 2 && v[15]) v |= 32'hFFFF_0000;
            e_data[b] = v;
            e_flt[b]  = f;
            e_last[b] = f || (b == eff);
            n_exp++;
            if (f) break;
        end
        wd_in.delete();

        bus.req_write  = wr;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = addr;
        bus.req_beats  = beats;
        bus.req_valid  = 1'b1;
        bus.wd_valid   = 1'b0;
        wr0 = wr_cnt;
        budget = 0;
        while (!bus.req_ready && budget < 50) begin
            @(negedge clock);
            budget++;
        end
        chk("req_ready", bus.req_ready, 1);
        @(posedge clock);
        @(negedge clock);
        bus.req_valid = 1'b0;
        acc = cyc;
        if (chk_gap) chk("accept_gap", acc - last_acc, 2);
        last_acc = acc;
        budget = 0;
        while (!fin && budget < 300) begin
            if (bus.rsp_valid) begin
                if (got < n_exp) begin
                    if (got == 0 && !wr) chk("load_latency", cyc - acc, 1);
                    chk("rsp_data", bus.rsp_data, e_data[got]);
                    chk("rsp_fault", bus.rsp_fault, e_flt[got]);
                    chk("rsp_last", bus.rsp_last, e_last[got]);
                    fin = e_last[got];
                end else begin
                    chk("extra_rsp", 1, 0);
                end
                got++;
            end
            if (fin) break;
            if (wr) begin
                if (gap > 0) begin
                    bus.wd_valid = 1'b0;
                    gap--;
                end else begin
                    bus.wd_valid = 1'b1;
                    bus.wd_data  = (used < n_exp) ? e_wd[used] : 32'hDEAD_BEEF;
                end
            end
            #1;
            idx = wr ? used : got;
            if (idx < n_exp) begin
                chk("em_address", bus.em_address, exp_lanes(addr + 10'(4 * idx), nb));
                chk("em_control", bus.em_control,
                    (wr && bus.wd_valid && !e_flt[idx]) ? code : 0);
            end
            if (bus.wd_valid && bus.wd_ready) begin
                used++;
                if (gap_fix >= 0) gap = gap_fix;
                else gap = (int'($urandom_range(99)) < stall_pct) ? int'($urandom_range(3, 1)) : 0;
            end
            @(negedge clock);
            budget++;
        end
        bus.wd_valid = 1'b0;
        chk("req_done", fin, 1);
        chk("rsp_count", got, n_exp);
        chk("wd_used", used, wr ? n_exp : 0);
        chk("mem_writes", wr_cnt - wr0, n_wr);
    endtask

    logic [31:0] w0, w1;
    int          wr0, bad;

    initial begin
        reset          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_size   = 2'd0;
        bus.req_signed = 1'b0;
        bus.req_addr   = 10'd0;
        bus.req_beats  = 4'd0;
        bus.wd_valid   = 1'b0;
        bus.wd_data    = 32'd0;
        for (int i = 0; i < MEM; i++) ref_mem[i] = 8'($urandom);
        ref_mem[64] = 8'd1; ref_mem[65] = 8'd5; ref_mem[66] = 8'd8;
        ref_mem[67] = 8'd7; ref_mem[68] = 8'd6; ref_mem[13] = 8'h93;
        load_mem = 1'b1;
        repeat (2) @(negedge clock);
        load_mem = 1'b0;

        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_wd_ready", bus.wd_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_fault", bus.rsp_fault, 0);
        chk("rst_rsp_last", bus.rsp_last, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_em_control", bus.em_control, 0);
        chk("rst_em_address", bus.em_address, 0);
        chk("rst_em_dw", {bus.em_dw3, bus.em_dw2, bus.em_dw1, bus.em_dw0}, 0);
        reset = 1'b1;
        @(negedge clock);

        do_req(1'b0, 2'd2, 1'b0, 10'd64, 4'd0, 0, -1, 1'b0);
        do_req(1'b0, 2'd0, 1'b1, 10'd13, 4'd0, 0, -1, 1'b0);
        do_req(1'b0, 2'd0, 1'b0, 10'd13, 4'd0, 0, -1, 1'b0);
        do_req(1'b0, 2'd1, 1'b0, 10'd94, 4'd0, 0, -1, 1'b0);
        do_req(1'b0, 2'd2, 1'b0, 10'd94, 4'd0, 0, -1, 1'b0);
        wd_in.push_back(32'h1122_3344);
        wd_in.push_back(32'hAABB_CCDD);
        do_req(1'b1, 2'd2, 1'b0, 10'd64, 4'd1, 0, 2, 1'b0);
        do_req(1'b0, 2'd2, 1'b0, 10'd64, 4'd1, 0, -1, 1'b0);
        do_req(1'b1, 2'd2, 1'b0, 10'd88, 4'd3, 0, 0, 1'b0);
        do_req(1'b0, 2'd0, 1'b1, 10'd20, 4'd0, 0, -1, 1'b0);
        do_req(1'b0, 2'd0, 1'b0, 10'd21, 4'd0, 0, -1, 1'b1);
        do_req(1'b0, 2'd3, 1'b0, 10'd40, 4'd0, 0, -1, 1'b1);

        // Reset asserted while the second beat of a four-beat store is on the bus.
        w0 = $urandom;
        w1 = $urandom;
        bus.req_write  = 1'b1;
        bus.req_size   = 2'd2;
        bus.req_signed = 1'b0;
        bus.req_addr   = 10'd0;
        bus.req_beats  = 4'd3;
        bus.req_valid  = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.req_valid = 1'b0;
        bus.wd_valid  = 1'b1;
        bus.wd_data   = w0;
        @(posedge clock);
        @(negedge clock);
        chk("rst_beat0_rsp", bus.rsp_valid, 1);
        bus.wd_data = w1;
        #1;
        chk("rst_beat1_ctl", bus.em_control, 3);
        reset = 1'b0;
        #1;
        chk("rst_mid_ctl", bus.em_control, 0);
        chk("rst_mid_rsp", bus.rsp_valid, 0);
        chk("rst_mid_req_ready", bus.req_ready, 0);
        chk("rst_mid_wd_ready", bus.wd_ready, 0);
        wr0 = wr_cnt;
        @(posedge clock);
        @(negedge clock);
        chk("rst_no_write", wr_cnt - wr0, 0);
        reset = 1'b1;
        bus.wd_valid = 1'b0;
        @(negedge clock);
        chk("rst_release_ready", bus.req_ready, 1);
        chk("rst_release_rsp", bus.rsp_valid, 0);
        for (int k = 0; k < 4; k++) ref_mem[k] = w0[8*k +: 8];

        for (int n = 0; n < 60; n++) begin
            logic [9:0] a;
            a = ($urandom_range(99) < 75) ? 10'($urandom_range(100)) : 10'($urandom_range(1023));
            do_req(1'($urandom), 2'($urandom), 1'($urandom), a, 4'($urandom_range(6)),
                   int'($urandom_range(60)), -1, 1'b0);
        end

        bad = 0;
        for (int i = 0; i < MEM; i++) if (mem[i] !== ref_mem[i]) bad++;
        chk("mem_image", bad, 0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
